pwm_generator: RTL and testbench



---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_phase_counter.sv | 45 ++++
 rtl/pwm_generator.sv | 115 +++++++++++
 tb/tb_pwm_generator.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and types for the PWM generator
//
// Purpose: default counter width and the phase encoding used by
// pwm_generator and pwm_phase_counter.
// Ports: none (package).
package pwm_pkg;

    localparam int PWM_WIDTH = 16;

    typedef enum logic {
        PHASE_HIGH = 1'b0,
        PHASE_LOW  = 1'b1
    } pwm_phase_e;

endpackage : pwm_pkg

// File: rtl/pwm_phase_counter.sv
// rtl/pwm_phase_counter.sv - enabled phase counter with terminal-count compare
//
// Purpose: counts enabled cycles inside the current PWM phase and flags the
// last cycle of that phase. A zero-length phase is treated as lasting one
// enabled cycle, so terminal is asserted immediately.
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   synchronous active-high reset, clears the count
//   clk_en    in   count enable; count holds when low
//   length    in   length of the current phase in enabled cycles
//   terminal  out  current enabled cycle is the last of the phase
//   zero_len  out  current phase length is zero
module pwm_phase_counter
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] length,
    output logic             terminal,
    output logic             zero_len
);

    logic [WIDTH-1:0] count;

    assign zero_len = (length == '0);
    // length-1 is only meaningful when length is nonzero; zero_len covers the rest,
    // so count never has to go past length-1 and cannot wrap.
    assign terminal = zero_len || (count == (length - WIDTH'(1)));

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clk_en) begin
            if (terminal) begin
                count <= '0;
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule : pwm_phase_counter

// File: rtl/pwm_generator.sv
// rtl/pwm_generator.sv - programmable single-channel PWM generator
//
// Purpose: drives pwm_out high for pwm_on enabled cycles and low for pwm_off
// enabled cycles. On/off words are captured into shadow registers at reset and
// at each period boundary, so mid-period changes apply to the next period.
// Optional feature macro: PWM_PERIOD_PULSE_EN (period_start pulse); when
// undefined period_start is tied low.
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   synchronous active-high reset / config-write strobe
//   clk_en        in   prescaler tick; state advances only when high
//   pwm_on        in   high-phase length in enabled cycles
//   pwm_off       in   low-phase length in enabled cycles
//   pwm_out       out  registered PWM waveform
//   period_start  out  one-clock pulse at position 0 of each period
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] pwm_on,
    input  logic [WIDTH-1:0] pwm_off,
    output logic             pwm_out,
    output logic             period_start
);

    logic [WIDTH-1:0] shadow_on;
    logic [WIDTH-1:0] shadow_off;
    pwm_phase_e       phase;
    pwm_phase_e       phase_next;
    logic [WIDTH-1:0] phase_len;
    logic             terminal;
    logic             zero_len;
    logic             out_next;
    logic             reload;

    assign phase_len = (phase == PHASE_HIGH) ? shadow_on : shadow_off;

    pwm_phase_counter #(
        .WIDTH    (WIDTH)
    ) u_counter (
        .clock    (clock),
        .reset    (reset),
        .clk_en   (clk_en),
        .length   (phase_len),
        .terminal (terminal),
        .zero_len (zero_len)
    );

    always_comb begin
        phase_next = phase;
        out_next   = 1'b0;
        reload     = 1'b0;
        case (phase)
            PHASE_HIGH: begin
                out_next = !zero_len;
                if (terminal) begin
                    phase_next = PHASE_LOW;
                end
            end
            PHASE_LOW: begin
                // A zero-length low phase keeps the line high so off=0 gives
                // a steady 1 rather than a one-cycle glitch each period.
                out_next = zero_len && (shadow_on != '0);
                if (terminal) begin
                    phase_next = PHASE_HIGH;
                    reload     = 1'b1;
                end
            end
            default: begin
                phase_next = PHASE_HIGH;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase      <= PHASE_HIGH;
            pwm_out    <= 1'b0;
            shadow_on  <= pwm_on;
            shadow_off <= pwm_off;
        end else if (clk_en) begin
            phase   <= phase_next;
            pwm_out <= out_next;
            if (reload) begin
                shadow_on  <= pwm_on;
                shadow_off <= pwm_off;
            end
        end
    end

`ifdef PWM_PERIOD_PULSE_EN
    // at_start marks that the next enabled edge processes position 0 of a
    // period: true after reset and after the low phase terminates.
    logic at_start;

    always_ff @(posedge clock) begin
        if (reset) begin
            at_start     <= 1'b1;
            period_start <= 1'b0;
        end else begin
            period_start <= clk_en && at_start;
            if (clk_en) begin
                at_start <= reload;
            end
        end
    end
`else
    assign period_start = 1'b0;
`endif

endmodule : pwm_generator

// File: tb/tb_pwm_generator.sv
// tb/tb_pwm_generator.sv - randomized self-checking bench for pwm_generator
module tb_pwm_generator;

    localparam int W   = 8;
    localparam int MAXV = (1 << W) - 1;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         clk_en = 1'b0;
    logic [W-1:0] pwm_on = '0;
    logic [W-1:0] pwm_off = '0;
    logic         pwm_out;
    logic         period_start;

    always #5 clock = ~clock;

    pwm_generator #(
        .WIDTH        (W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .clk_en       (clk_en),
        .pwm_on       (pwm_on),
        .pwm_off      (pwm_off),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference: position inside the period plus the on/off values of the
    // period in progress. Output follows ((pos) < on), with off=0 meaning a
    // steady high whenever on is nonzero.
    int m_pos   = 0;
    int m_on    = 0;
    int m_off   = 0;
    bit m_out   = 1'b0;
    bit m_start = 1'b0;

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    task automatic model_edge(input bit r, input bit e, input int on, input int off);
        int period;
        if (r) begin
            m_pos   = 0;
            m_on    = on;
            m_off   = off;
            m_out   = 1'b0;
            m_start = 1'b0;
        end else if (e) begin
            period  = max1(m_on) + max1(m_off);
            m_out   = (m_pos < m_on) || (m_off == 0 && m_on != 0);
            m_start = (m_pos == 0);
            m_pos++;
            if (m_pos == period) begin
                m_pos = 0;
                m_on  = on;
                m_off = off;
            end
        end else begin
            m_start = 1'b0;
        end
    endtask

    task automatic step(input bit r, input bit e, input int on, input int off);
        bit exp_start;
        reset   = r;
        clk_en  = e;
        pwm_on  = on[W-1:0];
        pwm_off = off[W-1:0];
        @(posedge clock);
        model_edge(r, e, on, off);
        #1;
`ifdef PWM_PERIOD_PULSE_EN
        exp_start = m_start;
`else
        exp_start = 1'b0;
`endif
        check("pwm_out", pwm_out, m_out);
        check("period_start", period_start, exp_start);
        @(negedge clock);
    endtask

    function automatic int rnd_val();
        if ($urandom_range(0, 9) == 9) begin
            return int'($urandom_range(MAXV - 3, MAXV));
        end
        return int'($urandom_range(0, 6));
    endfunction

    initial begin
        @(negedge clock);

        // basic 3/2 waveform
        step(1'b1, 1'b0, 3, 2);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 3, 2);

        // enable gating, tick every 4th clock
        step(1'b1, 1'b0, 2, 2);
        for (int i = 0; i < 40; i++) step(1'b0, (i % 4) == 3, 2, 2);

        // zero-length boundaries
        step(1'b1, 1'b0, 0, 5);
        for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 0, 5);
        step(1'b1, 1'b0, 4, 0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 4, 0);
        step(1'b1, 1'b1, 0, 0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 0, 0);

        // shadow reload: change mid-period at the 2nd high cycle
        step(1'b1, 1'b0, 3, 3);
        step(1'b0, 1'b1, 3, 3);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1, 1);

        // reset at the 3rd high cycle aborts the period
        step(1'b1, 1'b0, 5, 5);
        step(1'b0, 1'b1, 5, 5);
        step(1'b0, 1'b1, 5, 5);
        step(1'b1, 1'b1, 5, 5);
        for (int i = 0; i < 22; i++) step(1'b0, 1'b1, 5, 5);

        // maximum phase length without wrap
        step(1'b1, 1'b0, MAXV, 1);
        for (int i = 0; i < 2 * (MAXV + 1) + 4; i++) step(1'b0, 1'b1, MAXV, 1);
        step(1'b1, 1'b0, 2, MAXV);
        for (int i = 0; i < 2 * (MAXV + 2) + 4; i++) step(1'b0, 1'b1, 2, MAXV);

        // randomized segments: random enables, mid-period changes, resets
        for (int s = 0; s < 25; s++) begin
            int on_v;
            int off_v;
            on_v  = rnd_val();
            off_v = rnd_val();
            step(1'b1, $urandom_range(0, 1) == 1, on_v, off_v);
            for (int i = 0; i < 120; i++) begin
                if ($urandom_range(0, 19) == 0) begin
                    on_v  = rnd_val();
                    off_v = rnd_val();
                end
                step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, on_v, off_v);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pwm_generator
